// File: rtl/regfile_pkg.sv
// Shared types and the write-priority helper for the multi-port register file.
// Commit and bypass both go through write_sel so they can never disagree.
package regfile_pkg;

    typedef enum logic {CLEAR, RUN} rf_state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_TRIG,
        SEL_CORE,
        SEL_EXT
    } wsel_t;

    // Same-address conflicts resolve trigger > core > ext.
    function automatic wsel_t write_sel(input logic trig_hit,
                                        input logic core_hit,
                                        input logic ext_hit);
        if (trig_hit) return SEL_TRIG;
        if (core_hit) return SEL_CORE;
        if (ext_hit)  return SEL_EXT;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port select: x0 forcing, blanking while clearing, optional write-through.
module regfile_bypass_mux
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int BYPASS        = 1,
    parameter int TRIG_REG      = 5
) (
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic                     busy,
    input  logic                     trigger,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0]    wd,
    input  logic                     ext_we,
    input  logic [ADDRESS_WIDTH-1:0] ext_wa,
    input  logic [DATA_WIDTH-1:0]    ext_wd,
    input  logic [DATA_WIDTH-1:0]    arr_data,
    output logic [DATA_WIDTH-1:0]    data
);

    localparam logic [ADDRESS_WIDTH-1:0] TRIG_IDX = ADDRESS_WIDTH'(TRIG_REG);

    wsel_t sel;

    always_comb begin
        sel  = write_sel(trigger && (addr == TRIG_IDX),
                         we && (addr == wa),
                         ext_we && (addr == ext_wa));
        data = arr_data;
        if (BYPASS != 0) begin
            case (sel)
                SEL_TRIG: data = DATA_WIDTH'(1);
                SEL_CORE: data = wd;
                SEL_EXT:  data = ext_wd;
                default:  data = arr_data;
            endcase
        end
        if (busy || (addr == '0)) data = '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// Integer register file: NUM_RD read ports, core + external write ports, t0 trigger,
// hard-wired x0 and a one-entry-per-cycle clear sequencer after reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_RD        = 2,
    parameter int BYPASS        = 1,
    parameter int TRIG_REG      = 5,
    parameter int A0_REG        = 10,
    parameter int RA_REG        = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
    input  logic                            we,
    input  logic [ADDRESS_WIDTH-1:0]        wa,
    input  logic [DATA_WIDTH-1:0]           wd,
    input  logic                            ext_we,
    input  logic [ADDRESS_WIDTH-1:0]        ext_wa,
    input  logic [DATA_WIDTH-1:0]           ext_wd,
    input  logic                            trigger,
    output logic                            init_busy,
    output logic [DATA_WIDTH-1:0]           a0,
    output logic [DATA_WIDTH-1:0]           ra
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] TRIG_IDX = ADDRESS_WIDTH'(TRIG_REG);
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX   = ADDRESS_WIDTH'(A0_REG);
    localparam logic [ADDRESS_WIDTH-1:0] RA_IDX   = ADDRESS_WIDTH'(RA_REG);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    rf_state_t                state;
    logic [ADDRESS_WIDTH-1:0] clr_idx;

    // Entry 0 is never cleared or written; every reader forces it to zero instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= ADDRESS_WIDTH'(1);
        end else if (state == CLEAR) begin
            mem[clr_idx] <= '0;
            clr_idx      <= clr_idx + 1'b1;
            if (clr_idx == '1) state <= RUN;
        end else begin
            for (int j = 1; j < DEPTH; j++) begin
                case (write_sel(trigger && (ADDRESS_WIDTH'(j) == TRIG_IDX),
                                we && (ADDRESS_WIDTH'(j) == wa),
                                ext_we && (ADDRESS_WIDTH'(j) == ext_wa)))
                    SEL_TRIG: mem[j] <= DATA_WIDTH'(1);
                    SEL_CORE: mem[j] <= wd;
                    SEL_EXT:  mem[j] <= ext_wd;
                    default:  ;
                endcase
            end
        end
    end

    assign init_busy = (state == CLEAR);

    // Exported registers show committed contents only, never in-flight writes.
    assign a0 = (init_busy || A0_IDX == '0) ? '0 : mem[A0_IDX];
    assign ra = (init_busy || RA_IDX == '0) ? '0 : mem[RA_IDX];

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr;
        assign addr = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        regfile_bypass_mux #(
            .ADDRESS_WIDTH(ADDRESS_WIDTH),
            .DATA_WIDTH   (DATA_WIDTH),
            .BYPASS       (BYPASS),
            .TRIG_REG     (TRIG_REG)
        ) u_mux (
            .addr    (addr),
            .busy    (init_busy),
            .trigger (trigger),
            .we      (we),
            .wa      (wa),
            .wd      (wd),
            .ext_we  (ext_we),
            .ext_wa  (ext_wa),
            .ext_wd  (ext_wd),
            .arr_data(mem[addr]),
            .data    (rd_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_b, rd_data_n;
    logic        we, ext_we, trigger;
    logic [4:0]  wa, ext_wa;
    logic [31:0] wd, ext_wd;
    logic        busy_b, busy_n;
    logic [31:0] a0_b, a0_n, ra_b, ra_n;

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_q[$];

    regfile_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .we(we), .wa(wa), .wd(wd), .ext_we(ext_we), .ext_wa(ext_wa), .ext_wd(ext_wd),
        .trigger(trigger), .init_busy(busy_b), .a0(a0_b), .ra(ra_b)
    );

    regfile_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .we(we), .wa(wa), .wd(wd), .ext_we(ext_we), .ext_wa(ext_wa), .ext_wd(ext_wd),
        .trigger(trigger), .init_busy(busy_n), .a0(a0_n), .ra(ra_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    function automatic logic [31:0] port(input logic [63:0] v, input int p);
        return v[p*32 +: 32];
    endfunction

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts cycles with init_busy high, bounded so a stuck sequencer still ends the run.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while ((busy_b || busy_n) && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        int cnt;
        logic [4:0]  r;
        logic [31:0] d;

        rst = 1'b1; rd_addr = '0; we = 1'b0; wa = '0; wd = '0;
        ext_we = 1'b0; ext_wa = '0; ext_wd = '0; trigger = 1'b0;

        // Power-up reset and first clear
        repeat (2) tick();
        rst = 1'b0;
        expect_val(32'd31);
        count_busy(cnt);
        check("power_clear_len", 32'(cnt));

        // Preload x10 and x1 through the external port
        ext_we = 1'b1; ext_wa = 5'd10; ext_wd = 32'h0000_0055;
        tick();
        ext_wa = 5'd1; ext_wd = 32'h0000_0066;
        tick();
        ext_we = 1'b0;
        #1;
        expect_val(32'h55); check("preload_a0", a0_b);
        expect_val(32'h66); check("preload_ra", ra_n);

        // Reset pulse with core writes hammering x10 during the clear
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1; wa = 5'd10; wd = 32'hDEAD_BEEF;
        set_rd(0, 5'd10); set_rd(1, 5'd1);
        #1;
        expect_val(32'd1); check("busy_after_rst", 32'(busy_b));
        expect_val(32'd0); check("busy_rd0_blank", port(rd_data_b, 0));
        expect_val(32'd0); check("busy_rd1_blank", port(rd_data_n, 1));
        expect_val(32'd0); check("busy_a0_blank", a0_n);
        expect_val(32'd31);
        count_busy(cnt);
        check("clear_len", 32'(cnt));
        we = 1'b0;
        #1;
        expect_val(32'd0); check("blocked_a0", a0_b);
        expect_val(32'd0); check("blocked_ra", ra_b);
        expect_val(32'd0); check("blocked_rd_x10", port(rd_data_n, 0));
        for (int i = 0; i < 32; i++) begin
            set_rd(0, 5'(i)); set_rd(1, 5'(i));
            #1;
            expect_val(32'd0); check("cleared_b", port(rd_data_b, 0));
            expect_val(32'd0); check("cleared_n", port(rd_data_n, 1));
        end

        // Reset re-asserted at busy cycle 10
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_val(32'd31);
        count_busy(cnt);
        check("midclear_len", 32'(cnt));

        // x0 is hard-wired
        tick();
        we = 1'b1; wa = 5'd0; wd = 32'h0000_1234; set_rd(0, 5'd0);
        #1;
        expect_val(32'd0); check("x0_same_b", port(rd_data_b, 0));
        expect_val(32'd0); check("x0_same_n", port(rd_data_n, 0));
        tick();
        we = 1'b0;
        #1;
        expect_val(32'd0); check("x0_later_b", port(rd_data_b, 0));
        expect_val(32'd0); check("x0_later_n", port(rd_data_n, 0));

        // Write-through bypass versus registered read
        tick();
        we = 1'b1; wa = 5'd3; wd = 32'hA5A5_A5A5; set_rd(1, 5'd3);
        #1;
        expect_val(32'hA5A5_A5A5); check("bypass_same", port(rd_data_b, 1));
        expect_val(32'd0);         check("nobypass_old", port(rd_data_n, 1));
        tick();
        we = 1'b0;
        #1;
        expect_val(32'hA5A5_A5A5); check("nobypass_next", port(rd_data_n, 1));
        expect_val(32'hA5A5_A5A5); check("bypass_next", port(rd_data_b, 1));

        // Priority trigger > core > ext on x5
        tick();
        trigger = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'd7;
        ext_we = 1'b1; ext_wa = 5'd5; ext_wd = 32'd9; set_rd(0, 5'd5);
        #1;
        expect_val(32'd1); check("prio_trig_byp", port(rd_data_b, 0));
        expect_val(32'd0); check("prio_trig_old", port(rd_data_n, 0));
        tick();
        trigger = 1'b0;
        #1;
        expect_val(32'd1); check("prio_trig_commit", port(rd_data_n, 0));
        expect_val(32'd7); check("prio_core_byp", port(rd_data_b, 0));
        tick();
        we = 1'b0;
        #1;
        expect_val(32'd7); check("prio_core_commit", port(rd_data_n, 0));
        expect_val(32'd9); check("prio_ext_byp", port(rd_data_b, 0));
        tick();
        ext_we = 1'b0;
        #1;
        expect_val(32'd9); check("prio_ext_commit_n", port(rd_data_n, 0));
        expect_val(32'd9); check("prio_ext_commit_b", port(rd_data_b, 0));

        // Three writes to distinct addresses all commit; a0/ra never bypass
        tick();
        trigger = 1'b1; we = 1'b1; wa = 5'd10; wd = 32'hCAFE_0001;
        ext_we = 1'b1; ext_wa = 5'd1; ext_wd = 32'hBEEF_0002;
        #1;
        expect_val(32'd0); check("a0_no_bypass", a0_b);
        expect_val(32'd0); check("ra_no_bypass", ra_b);
        tick();
        trigger = 1'b0; we = 1'b0; ext_we = 1'b0;
        #1;
        expect_val(32'hCAFE_0001); check("multi_a0", a0_b);
        expect_val(32'hBEEF_0002); check("multi_ra", ra_n);
        expect_val(32'd1);         check("multi_trig_x5", port(rd_data_n, 0));

        // Random core write / read-back
        for (int k = 0; k < 16; k++) begin
            tick();
            r = 5'($urandom_range(1, 31));
            d = $urandom;
            we = 1'b1; wa = r; wd = d;
            tick();
            we = 1'b0; set_rd(0, r); set_rd(1, r);
            #1;
            expect_val(d); check("rand_rd_b", port(rd_data_b, 0));
            expect_val(d); check("rand_rd_n", port(rd_data_n, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
